// File: rtl/writeback_regfile.sv
// Write-back stage and general register file.
// Selects the W-stage result (load data or ALU result), commits it to a
// 2**ADDR_W x DATA_W register file, and serves two combinational read ports.
// The read ports give a written value in the same cycle as its write
// (write-first bypass). The selected result is also exported for forwarding.
module writeback_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemToRegW,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] destAddW,
    input  logic [DATA_W-1:0] MemReadDataW,
    input  logic [DATA_W-1:0] alu_resultW,
    input  logic [ADDR_W-1:0] srcAddA,
    input  logic [ADDR_W-1:0] srcAddB,
    output logic [DATA_W-1:0] readDataA,
    output logic [DATA_W-1:0] readDataB,
    output logic [DATA_W-1:0] resultW,
    output logic              wbValidW,
    output logic [15:0]       wbCount
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam bit HARD_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regFile [NUM_REGS];

    // Result select is a plain mux; no width change.
    assign resultW = MemToRegW ? MemReadDataW : alu_resultW;

    // A write to R0 is dropped entirely when R0 is hardwired to zero.
    // RegWriteW gates everything, so don't-care address/data cannot leak in.
    assign wbValidW = RegWriteW & ~(HARD_ZERO & (destAddW == '0));

    // One storage word per register; each word only loads when it is the
    // committed destination. Async clear keeps reset effective immediately.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regFile[gi] <= '0;
                end else if (wbValidW && (destAddW == ADDR_W'(gi))) begin
                    regFile[gi] <= resultW;
                end
            end
        end
    endgenerate

    // Commit counter; natural 16-bit wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbCount <= '0;
        end else if (wbValidW) begin
            wbCount <= wbCount + 16'd1;
        end
    end

    // Read port priority: reset/zero-register forcing beats the bypass,
    // and the bypass beats storage.
    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = regFile[addr];
        if (wbValidW && (addr == destAddW)) begin
            value = resultW;
        end
        if (reset || (HARD_ZERO && (addr == '0))) begin
            value = '0;
        end
        return value;
    endfunction

    // Port A read (combinational).
    always_comb begin
        readDataA = readPort(srcAddA);
    end

    // Port B read (combinational).
    always_comb begin
        readDataB = readPort(srcAddB);
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: one instance with a hardwired R0 and
// one with an ordinary R0, driven from the same stimulus.
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic        MemToRegW;
    logic        RegWriteW;
    logic [3:0]  destAddW;
    logic [15:0] MemReadDataW;
    logic [15:0] alu_resultW;
    logic [3:0]  srcAddA;
    logic [3:0]  srcAddB;

    logic [15:0] readDataA, readDataB, resultW, wbCount;
    logic        wbValidW;
    logic [15:0] readDataANz, readDataBNz, resultWNz, wbCountNz;
    logic        wbValidWNz;

    int testsRun = 0;
    int testsFailed = 0;

    logic [15:0] refRegs [16];
    logic [15:0] refNz [16];
    logic [15:0] refCount;
    logic [15:0] refCountNz;

    writeback_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW),
        .destAddW(destAddW), .MemReadDataW(MemReadDataW), .alu_resultW(alu_resultW),
        .srcAddA(srcAddA), .srcAddB(srcAddB), .readDataA(readDataA), .readDataB(readDataB),
        .resultW(resultW), .wbValidW(wbValidW), .wbCount(wbCount)
    );

    writeback_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dutNz (
        .clk(clk), .reset(reset), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW),
        .destAddW(destAddW), .MemReadDataW(MemReadDataW), .alu_resultW(alu_resultW),
        .srcAddA(srcAddA), .srcAddB(srcAddB), .readDataA(readDataANz), .readDataB(readDataBNz),
        .resultW(resultWNz), .wbValidW(wbValidWNz), .wbCount(wbCountNz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    task automatic clearModel();
        for (int i = 0; i < 16; i++) begin
            refRegs[i] = 16'h0000;
            refNz[i] = 16'h0000;
        end
        refCount = 16'h0000;
        refCountNz = 16'h0000;
    endtask

    // Drive one write at the falling edge, clock it in, update the models.
    task automatic doCommit(input logic [3:0] dest, input logic [15:0] mem,
                            input logic [15:0] alu, input logic m2r);
        logic [15:0] res;
        @(negedge clk);
        RegWriteW = 1'b1; destAddW = dest; MemReadDataW = mem;
        alu_resultW = alu; MemToRegW = m2r;
        res = m2r ? mem : alu;
        @(posedge clk);
        if (dest != 4'd0) begin
            refRegs[dest] = res;
            refCount = refCount + 16'd1;
        end
        refNz[dest] = res;
        refCountNz = refCountNz + 16'd1;
        #1;
        RegWriteW = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        @(negedge clk);
        srcAddA = 4'd5; srcAddB = 4'd3;
        #1;
        testsRun++;
        if (readDataA !== 16'h0000 || readDataB !== 16'h0000 || wbCount !== 16'h0000) begin
            testsFailed++;
            $display("FAIL reset_por: rdA=%h rdB=%h cnt=%h, required 0000 0000 0000", readDataA, readDataB, wbCount);
        end
        @(negedge clk);
        reset = 1'b0;
        clearModel();
        // Load R5 then assert reset mid-run with a write pending.
        doCommit(4'd5, 16'h0000, 16'h1234, 1'b0);
        srcAddA = 4'd5; srcAddB = 4'd5;
        #1;
        testsRun++;
        if (readDataA !== 16'h1234 || wbCount !== 16'd1) begin
            testsFailed++;
            $display("FAIL reset_preload: rdA=%h cnt=%h, required 1234 0001", readDataA, wbCount);
        end
        @(negedge clk);
        RegWriteW = 1'b1; MemToRegW = 1'b0; destAddW = 4'd5; alu_resultW = 16'hFFFF;
        reset = 1'b1;
        #1;
        testsRun++;
        if (readDataA !== 16'h0000 || readDataB !== 16'h0000 || wbCount !== 16'h0000 ||
            readDataANz !== 16'h0000 || wbCountNz !== 16'h0000) begin
            testsFailed++;
            $display("FAIL reset_async: rdA=%h rdB=%h cnt=%h rdANz=%h cntNz=%h, required all 0000",
                     readDataA, readDataB, wbCount, readDataANz, wbCountNz);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (readDataA !== 16'h0000 || wbCount !== 16'h0000 || wbCountNz !== 16'h0000) begin
            testsFailed++;
            $display("FAIL reset_hold_write: rdA=%h cnt=%h cntNz=%h, required 0000 0000 0000",
                     readDataA, wbCount, wbCountNz);
        end
        @(negedge clk);
        RegWriteW = 1'b0;
        reset = 1'b0;
        clearModel();
        #1;
        testsRun++;
        if (readDataA !== 16'h0000 || readDataANz !== 16'h0000) begin
            testsFailed++;
            $display("FAIL reset_release: rdA=%h rdANz=%h, required 0000 0000", readDataA, readDataANz);
        end
    endtask

    task automatic test_alu_write();
        doCommit(4'd3, 16'h1111, 16'hA5A5, 1'b0);
        srcAddA = 4'd3;
        #1;
        testsRun++;
        if (readDataA !== 16'hA5A5 || wbCount !== 16'd1) begin
            testsFailed++;
            $display("FAIL alu_write: rdA=%h cnt=%h, required a5a5 0001", readDataA, wbCount);
        end
    endtask

    task automatic test_load_write();
        @(negedge clk);
        RegWriteW = 1'b1; MemToRegW = 1'b1; destAddW = 4'd7;
        MemReadDataW = 16'h0F0F; alu_resultW = 16'hFFFF;
        #1;
        testsRun++;
        if (resultW !== 16'h0F0F || wbValidW !== 1'b1) begin
            testsFailed++;
            $display("FAIL load_select: resultW=%h valid=%b, required 0f0f 1", resultW, wbValidW);
        end
        @(posedge clk);
        refRegs[7] = 16'h0F0F; refNz[7] = 16'h0F0F;
        refCount = refCount + 16'd1; refCountNz = refCountNz + 16'd1;
        #1;
        RegWriteW = 1'b0; MemToRegW = 1'b0; srcAddB = 4'd7;
        #1;
        testsRun++;
        if (readDataB !== 16'h0F0F || wbCount !== 16'd2) begin
            testsFailed++;
            $display("FAIL load_write: rdB=%h cnt=%h, required 0f0f 0002", readDataB, wbCount);
        end
    endtask

    task automatic test_bypass();
        doCommit(4'd9, 16'h0000, 16'h1111, 1'b0);
        @(negedge clk);
        RegWriteW = 1'b1; MemToRegW = 1'b0; destAddW = 4'd9; alu_resultW = 16'h5555;
        srcAddA = 4'd9; srcAddB = 4'd9;
        #1;
        testsRun++;
        if (readDataA !== 16'h5555 || readDataB !== 16'h5555) begin
            testsFailed++;
            $display("FAIL bypass_both: rdA=%h rdB=%h, required 5555 5555", readDataA, readDataB);
        end
        RegWriteW = 1'b0;
        #1;
        testsRun++;
        if (readDataA !== 16'h1111 || readDataB !== 16'h1111) begin
            testsFailed++;
            $display("FAIL bypass_off: rdA=%h rdB=%h, required 1111 1111", readDataA, readDataB);
        end
        doCommit(4'd9, 16'h0000, 16'h5555, 1'b0);
        #1;
        testsRun++;
        if (readDataA !== 16'h5555 || wbCount !== 16'd4) begin
            testsFailed++;
            $display("FAIL bypass_stored: rdA=%h cnt=%h, required 5555 0004", readDataA, wbCount);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        RegWriteW = 1'b1; MemToRegW = 1'b0; destAddW = 4'd0; alu_resultW = 16'hBEEF;
        srcAddA = 4'd0; srcAddB = 4'd0;
        #1;
        testsRun++;
        if (wbValidW !== 1'b0 || readDataA !== 16'h0000 || wbValidWNz !== 1'b1 || readDataANz !== 16'hBEEF) begin
            testsFailed++;
            $display("FAIL r0_same_cycle: valid=%b rdA=%h validNz=%b rdANz=%h, required 0 0000 1 beef",
                     wbValidW, readDataA, wbValidWNz, readDataANz);
        end
        @(posedge clk);
        refNz[0] = 16'hBEEF; refCountNz = refCountNz + 16'd1;
        #1;
        RegWriteW = 1'b0;
        #1;
        testsRun++;
        if (readDataA !== 16'h0000 || wbCount !== 16'd4 || readDataBNz !== 16'hBEEF || wbCountNz !== 16'd5) begin
            testsFailed++;
            $display("FAIL r0_after: rdA=%h cnt=%h rdBNz=%h cntNz=%h, required 0000 0004 beef 0005",
                     readDataA, wbCount, readDataBNz, wbCountNz);
        end
    endtask

    task automatic test_x_safety();
        @(negedge clk);
        RegWriteW = 1'b0; MemToRegW = 1'bx; destAddW = 4'bxxxx;
        MemReadDataW = 16'hxxxx; alu_resultW = 16'hxxxx;
        srcAddA = 4'd3; srcAddB = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        MemToRegW = 1'b0; destAddW = 4'd0; MemReadDataW = 16'h0; alu_resultW = 16'h0;
        #1;
        testsRun++;
        if (readDataA !== 16'hA5A5 || readDataB !== 16'h0F0F || wbCount !== 16'd4 || wbCountNz !== 16'd5) begin
            testsFailed++;
            $display("FAIL x_safety: rdA=%h rdB=%h cnt=%h cntNz=%h, required a5a5 0f0f 0004 0005",
                     readDataA, readDataB, wbCount, wbCountNz);
        end
    endtask

    task automatic test_count_wrap();
        int n;
        n = 16'hFFFF - int'(refCount);
        @(negedge clk);
        RegWriteW = 1'b1; MemToRegW = 1'b0; destAddW = 4'd1; alu_resultW = 16'h00AA;
        repeat (n) @(posedge clk);
        #1;
        RegWriteW = 1'b0;
        refRegs[1] = 16'h00AA; refNz[1] = 16'h00AA;
        refCount = refCount + 16'(n);
        refCountNz = refCountNz + 16'(n);
        testsRun++;
        if (wbCount !== 16'hFFFF || wbCountNz !== 16'h0000) begin
            testsFailed++;
            $display("FAIL count_full: cnt=%h cntNz=%h, required ffff 0000", wbCount, wbCountNz);
        end
        doCommit(4'd2, 16'h0000, 16'h0002, 1'b0);
        #1;
        testsRun++;
        if (wbCount !== 16'h0000 || wbCountNz !== 16'h0001) begin
            testsFailed++;
            $display("FAIL count_wrap: cnt=%h cntNz=%h, required 0000 0001", wbCount, wbCountNz);
        end
    endtask

    task automatic test_random();
        logic [3:0]  dest, sa, sb;
        logic [15:0] mem, alu, res, expA, expB;
        logic        we, m2r, valid;
        for (int it = 0; it < 300; it++) begin
            dest = 4'($urandom_range(0, 15));
            sa = 4'($urandom_range(0, 15));
            sb = 4'($urandom_range(0, 15));
            mem = 16'($urandom);
            alu = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            m2r = 1'($urandom_range(0, 1));
            res = m2r ? mem : alu;
            valid = we && (dest != 4'd0);
            expA = (sa == 4'd0) ? 16'h0000 : ((valid && sa == dest) ? res : refRegs[sa]);
            expB = (sb == 4'd0) ? 16'h0000 : ((valid && sb == dest) ? res : refRegs[sb]);
            @(negedge clk);
            RegWriteW = we; destAddW = dest; MemReadDataW = mem; alu_resultW = alu;
            MemToRegW = m2r; srcAddA = sa; srcAddB = sb;
            #1;
            testsRun++;
            if (readDataA !== expA || readDataB !== expB || resultW !== res) begin
                testsFailed++;
                $display("FAIL random[%0d]: rdA=%h rdB=%h res=%h, required %h %h %h",
                         it, readDataA, readDataB, resultW, expA, expB, res);
            end
            @(posedge clk);
            if (valid) begin
                refRegs[dest] = res;
                refCount = refCount + 16'd1;
            end
        end
        #1;
        RegWriteW = 1'b0;
        testsRun++;
        if (wbCount !== refCount) begin
            testsFailed++;
            $display("FAIL random_count: cnt=%h, required %h", wbCount, refCount);
        end
    endtask

    initial begin
        reset = 1'b1;
        MemToRegW = 1'b0; RegWriteW = 1'b0; destAddW = 4'd0;
        MemReadDataW = 16'h0; alu_resultW = 16'h0; srcAddA = 4'd0; srcAddB = 4'd0;
        clearModel();
        repeat (2) @(posedge clk);
        test_reset();
        test_alu_write();
        test_load_write();
        test_bypass();
        test_zero_reg();
        test_x_safety();
        test_count_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
